wb_retire_queue: RTL and testbench

Parametrised successor to the single-entry write-back stage. It buffers up to DEPTH completed instructions from the MEM stage in program order and retires one per cycle to the register file when the RF write port is granted. Exceptional instructions are routed to CP0, and younger entries are squashed. Multi-entry hazard query and forwarding ports replace the single write_reg/reg_dest stall pair used by ID.

---
 rtl/wb_retire_queue_pkg.sv | 36 +++
 rtl/wb_retire_queue_hazard_match.sv | 35 +++
 rtl/wb_retire_queue.sv | 165 ++++++++++++++++
 tb/tb_wb_retire_queue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_retire_queue_pkg.sv
// Shared types for the write-back retire queue:
// exception vector layout and the buffered entry format.
package wb_retire_queue_pkg;

   localparam int EX_W      = 9;
   localparam int WB_DATA_W = 32;

   localparam int EX_SYS  = 8;
   localparam int EX_MFC0 = 7;
   localparam int EX_MTC0 = 6;
   localparam int EX_ERET = 5;
   localparam int EX_BRK  = 4;
   localparam int EX_OV   = 3;
   localparam int EX_ADEL = 2;
   localparam int EX_ADES = 1;
   localparam int EX_RI   = 0;

   // mfc0/mtc0 are CP0 ops, not traps
   localparam logic [EX_W-1:0] EX_MASK = 9'b1_0011_1111;

   typedef struct packed {
      logic [3:0]           we;
      logic [4:0]           dest;
      logic [WB_DATA_W-1:0] result;
      logic [WB_DATA_W-1:0] pc;
      logic [EX_W-1:0]      ex;
      logic                 bd;
      logic [4:0]           c0_addr;
      logic [WB_DATA_W-1:0] badvaddr;
   } wb_entry_t;

   function automatic logic is_exc(input logic [EX_W-1:0] ex);
      return |(ex & EX_MASK);
   endfunction

endpackage

// File: rtl/wb_retire_queue_hazard_match.sv
// One ID hazard query port: finds the youngest pending
// write to q_reg among age-ordered queue entries.
module wb_hazard_match
   import wb_retire_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = WB_DATA_W
) (
   input  logic [DEPTH-1:0]             vld,
   input  logic [DEPTH-1:0][3:0]        we,
   input  logic [DEPTH-1:0][4:0]        dest,
   input  logic [DEPTH-1:0][DATA_W-1:0] result,
   input  logic [DEPTH-1:0]             nofwd,
   input  logic [4:0]                   q_reg,
   output logic                         hit,
   output logic                         fwd_ok,
   output logic [DATA_W-1:0]            data
);

   // index 0 is oldest, so the last match wins
   always_comb begin
      hit    = 1'b0;
      fwd_ok = 1'b0;
      data   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (vld[k] && (we[k] != 4'h0) &&
             (dest[k] == q_reg) && (q_reg != 5'd0)) begin
            hit    = 1'b1;
            data   = result[k];
            fwd_ok = (we[k] == 4'hf) && !nofwd[k];
         end
      end
   end

endmodule

// File: rtl/wb_retire_queue.sv
// Multi-entry write-back retire queue: in-order retire to
// the RF, exception hand-off to CP0, ID hazard/forward ports.
module wb_retire_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int NUM_Q  = 2,
   parameter int EX_W   = wb_retire_queue_pkg::EX_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              in_we,
   input  logic [4:0]              in_dest,
   input  logic [DATA_W-1:0]       in_result,
   input  logic [DATA_W-1:0]       in_pc,
   input  logic [EX_W-1:0]         in_ex,
   input  logic                    in_bd,
   input  logic [4:0]              in_c0_addr,
   input  logic [DATA_W-1:0]       in_badvaddr,
   input  logic                    rf_grant,
   input  logic                    flush,
   output logic [EX_W-1:0]         c0_exception,
   output logic [4:0]              c0_addr,
   output logic [DATA_W-1:0]       c0_wdata,
   output logic                    c0_wb_valid,
   output logic                    c0_wb_bd,
   output logic [DATA_W-1:0]       c0_wb_pc,
   output logic [DATA_W-1:0]       c0_badvaddr,
   input  logic                    c0_valid,
   input  logic [DATA_W-1:0]       c0_res,
   output logic                    ws_ex,
   output logic [3:0]              rf_we,
   output logic [4:0]              rf_waddr,
   output logic [DATA_W-1:0]       rf_wdata,
   input  logic [NUM_Q*5-1:0]      q_reg,
   output logic [NUM_Q-1:0]        q_hit,
   output logic [NUM_Q-1:0]        q_fwd_ok,
   output logic [NUM_Q*DATA_W-1:0] q_data,
   output logic [31:0]             debug_wb_pc,
   output logic [3:0]              debug_wb_rf_wen,
   output logic [4:0]              debug_wb_rf_wnum,
   output logic [31:0]             debug_wb_rf_wdata
);

   import wb_retire_queue_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t      mem [DEPTH];
   wb_entry_t      in_ent;
   wb_entry_t      hd;
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [CW-1:0]  count;
   logic           head_v;
   logic           head_ex;
   logic           pop;
   logic           ex_pop;
   logic           push;

   logic [DEPTH-1:0]             a_vld;
   logic [DEPTH-1:0][3:0]        a_we;
   logic [DEPTH-1:0][4:0]        a_dest;
   logic [DEPTH-1:0][DATA_W-1:0] a_res;
   logic [DEPTH-1:0]             a_nofwd;
   logic [PW-1:0]                idx;

   always_comb begin
      in_ent          = '0;
      in_ent.we       = in_we;
      in_ent.dest     = in_dest;
      in_ent.result   = in_result;
      in_ent.pc       = in_pc;
      in_ent.ex       = in_ex;
      in_ent.bd       = in_bd;
      in_ent.c0_addr  = in_c0_addr;
      in_ent.badvaddr = in_badvaddr;
   end

   // an empty queue presents an all-zero head
   assign head_v  = (count != '0);
   assign hd      = head_v ? mem[head] : '0;
   assign head_ex = head_v & is_exc(hd.ex);

   assign pop      = head_v & ~flush & (rf_grant | head_ex);
   assign ex_pop   = pop & head_ex;
   assign in_ready = (count < CW'(DEPTH)) | pop;
   assign push     = in_valid & in_ready & ~flush & ~ex_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush | ex_pop) begin
         head  <= tail;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= in_ent;
   end

   assign c0_exception = hd.ex;
   assign c0_addr      = hd.c0_addr;
   assign c0_wdata     = hd.result;
   assign c0_wb_valid  = pop;
   assign c0_wb_bd     = hd.bd;
   assign c0_wb_pc     = hd.pc;
   assign c0_badvaddr  = hd.badvaddr;
   assign ws_ex        = ex_pop;

   assign rf_we    = (pop & ~head_ex) ? hd.we : 4'h0;
   assign rf_waddr = hd.dest;
   assign rf_wdata = c0_valid ? c0_res : hd.result;

   assign debug_wb_pc       = hd.pc;
   assign debug_wb_rf_wen   = rf_we;
   assign debug_wb_rf_wnum  = hd.dest;
   assign debug_wb_rf_wdata = rf_wdata;

   // age-ordered view: slot 0 is the head
   always_comb begin
      idx     = '0;
      a_vld   = '0;
      a_we    = '0;
      a_dest  = '0;
      a_res   = '0;
      a_nofwd = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx        = head + PW'(k);
         a_vld[k]   = CW'(k) < count;
         a_we[k]    = mem[idx].we;
         a_dest[k]  = mem[idx].dest;
         a_res[k]   = mem[idx].result;
         a_nofwd[k] = mem[idx].ex[EX_MFC0] |
                      is_exc(mem[idx].ex);
      end
   end

   for (genvar i = 0; i < NUM_Q; i++) begin : g_q
      wb_hazard_match #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W)
      ) u_match (
         .vld    (a_vld),
         .we     (a_we),
         .dest   (a_dest),
         .result (a_res),
         .nofwd  (a_nofwd),
         .q_reg  (q_reg[i*5 +: 5]),
         .hit    (q_hit[i]),
         .fwd_ok (q_fwd_ok[i]),
         .data   (q_data[i*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: directed vector table, a
// queue-based reference model under random stimulus, resets.
module tb_wb_retire_queue;

   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int NQ    = 2;
   localparam int NV    = 31;
   localparam logic I = 1'b1;
   localparam logic O = 1'b0;
   localparam logic [8:0] MASK = 9'h13f;
   localparam logic [8:0] OVB  = 9'h008;
   localparam logic [8:0] MFB  = 9'h080;
   localparam logic [8:0] Z9   = 9'h000;
   localparam logic [31:0] Z32 = 32'h0;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid, in_ready;
   logic [3:0]     in_we;
   logic [4:0]     in_dest;
   logic [DW-1:0]  in_result, in_pc, in_badvaddr;
   logic [8:0]     in_ex;
   logic           in_bd;
   logic [4:0]     in_c0_addr;
   logic           rf_grant, flush;
   logic [8:0]     c0_exception;
   logic [4:0]     c0_addr;
   logic [DW-1:0]  c0_wdata, c0_wb_pc, c0_badvaddr;
   logic           c0_wb_valid, c0_wb_bd;
   logic           c0_valid;
   logic [DW-1:0]  c0_res;
   logic           ws_ex;
   logic [3:0]     rf_we;
   logic [4:0]     rf_waddr;
   logic [DW-1:0]  rf_wdata;
   logic [NQ*5-1:0]  q_reg;
   logic [NQ-1:0]    q_hit, q_fwd_ok;
   logic [NQ*DW-1:0] q_data;
   logic [31:0]    debug_wb_pc, debug_wb_rf_wdata;
   logic [3:0]     debug_wb_rf_wen;
   logic [4:0]     debug_wb_rf_wnum;

   always #5 clk = ~clk;

   wb_retire_queue #(
      .DEPTH(DEPTH), .DATA_W(DW), .NUM_Q(NQ), .EX_W(9)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_we(in_we), .in_dest(in_dest),
      .in_result(in_result), .in_pc(in_pc),
      .in_ex(in_ex), .in_bd(in_bd),
      .in_c0_addr(in_c0_addr), .in_badvaddr(in_badvaddr),
      .rf_grant(rf_grant), .flush(flush),
      .c0_exception(c0_exception), .c0_addr(c0_addr),
      .c0_wdata(c0_wdata), .c0_wb_valid(c0_wb_valid),
      .c0_wb_bd(c0_wb_bd), .c0_wb_pc(c0_wb_pc),
      .c0_badvaddr(c0_badvaddr),
      .c0_valid(c0_valid), .c0_res(c0_res),
      .ws_ex(ws_ex), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .q_reg(q_reg), .q_hit(q_hit),
      .q_fwd_ok(q_fwd_ok), .q_data(q_data),
      .debug_wb_pc(debug_wb_pc),
      .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum),
      .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   typedef struct {
      logic v; logic [3:0] we; logic [4:0] d;
      logic [31:0] res; logic [8:0] ex;
      logic g, fl, c0v; logic [31:0] c0r; logic [4:0] qr;
      logic rdy, pop, wsex; logic [3:0] rfwe;
      logic hd; logic [4:0] wa; logic [31:0] wd;
      logic [8:0] c0ex; logic hit, fwd; logic [31:0] qd;
   } vec_t;

   typedef struct {
      logic [3:0] we; logic [4:0] dest;
      logic [31:0] result, pc, bad;
      logic [8:0] ex; logic bd; logic [4:0] c0a;
   } ent_t;

   vec_t vt [NV];
   ent_t mq [$];
   ent_t cur, h;
   int   n_chk = 0;
   int   n_fail = 0;
   logic exp_pop, exp_hex, exp_push;

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic idle();
      in_valid = 0; in_we = 0; in_dest = 0;
      in_result = 0; in_pc = 0; in_badvaddr = 0;
      in_ex = 0; in_bd = 0; in_c0_addr = 0;
      rf_grant = 0; flush = 0; c0_valid = 0;
      c0_res = 0; q_reg = 0;
   endtask

   task automatic rand_in();
      int r;
      in_valid    = $urandom_range(0, 3) != 0;
      r           = $urandom_range(0, 3);
      in_we       = (r == 0) ? 4'h0 : (r == 1) ? 4'h3 : 4'hf;
      in_dest     = 5'($urandom_range(0, 7));
      in_result   = $urandom;
      in_pc       = $urandom;
      in_badvaddr = $urandom;
      in_ex = ($urandom_range(0, 7) == 0) ?
              9'(1 << $urandom_range(0, 8)) : 9'h0;
      in_bd       = 1'($urandom_range(0, 1));
      in_c0_addr  = 5'($urandom_range(0, 31));
      rf_grant    = $urandom_range(0, 9) < 7;
      flush       = $urandom_range(0, 29) == 0;
      c0_valid    = $urandom_range(0, 9) == 0;
      c0_res      = $urandom;
      q_reg = {5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7))};
   endtask

   task automatic model_check(input int c);
      logic hv, eh, ef;
      logic [31:0] ed;
      logic [4:0] qr;
      logic [3:0] erf;
      logic [31:0] ewd;
      hv = mq.size() != 0;
      h = '{default: '0};
      if (hv) h = mq[0];
      exp_hex = hv && ((h.ex & MASK) != 0);
      exp_pop = hv && !flush && (rf_grant || exp_hex);
      erf = (exp_pop && !exp_hex) ? h.we : 4'h0;
      ewd = c0_valid ? c0_res : h.result;
      check($sformatf("r%0d.rdy", c), in_ready,
            (mq.size() < DEPTH) || exp_pop);
      check($sformatf("r%0d.pop", c), c0_wb_valid, exp_pop);
      check($sformatf("r%0d.wsex", c), ws_ex,
            exp_pop && exp_hex);
      check($sformatf("r%0d.rfwe", c), rf_we, erf);
      check($sformatf("r%0d.dwen", c), debug_wb_rf_wen, erf);
      if (hv || c0_valid) begin
         check($sformatf("r%0d.wd", c), rf_wdata, ewd);
         check($sformatf("r%0d.dwd", c), debug_wb_rf_wdata, ewd);
      end
      if (hv) begin
         check($sformatf("r%0d.wa", c), rf_waddr, h.dest);
         check($sformatf("r%0d.pc", c), c0_wb_pc, h.pc);
         check($sformatf("r%0d.dpc", c), debug_wb_pc, h.pc);
         check($sformatf("r%0d.ex", c), c0_exception, h.ex);
         check($sformatf("r%0d.c0a", c), c0_addr, h.c0a);
         check($sformatf("r%0d.c0d", c), c0_wdata, h.result);
         check($sformatf("r%0d.bd", c), c0_wb_bd, h.bd);
         check($sformatf("r%0d.bad", c), c0_badvaddr, h.bad);
      end
      for (int q = 0; q < NQ; q++) begin
         qr = q_reg[q*5 +: 5];
         eh = 0; ef = 0; ed = 0;
         for (int j = mq.size() - 1; j >= 0; j--) begin
            if (mq[j].we != 0 && mq[j].dest == qr && qr != 0) begin
               eh = 1;
               ed = mq[j].result;
               ef = mq[j].we == 4'hf && !mq[j].ex[7] &&
                    (mq[j].ex & MASK) == 0;
               break;
            end
         end
         check($sformatf("r%0d.hit%0d", c, q), q_hit[q], eh);
         check($sformatf("r%0d.fwd%0d", c, q), q_fwd_ok[q], ef);
         check($sformatf("r%0d.qd%0d", c, q),
               q_data[q*DW +: DW], ed);
      end
      cur = '{we: in_we, dest: in_dest, result: in_result,
              pc: in_pc, bad: in_badvaddr, ex: in_ex,
              bd: in_bd, c0a: in_c0_addr};
      exp_push = in_valid && ((mq.size() < DEPTH) || exp_pop) &&
                 !flush && !(exp_pop && exp_hex);
   endtask

   task automatic model_update();
      if (flush || (exp_pop && exp_hex)) begin
         mq.delete();
      end else begin
         if (exp_pop) void'(mq.pop_front());
         if (exp_push) mq.push_back(cur);
      end
   endtask

   initial begin
      vt[0]  = '{I,4'hf,5'd5,32'h1234,Z9,I,O,O,Z32,5'd5, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};
      vt[1]  = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd5, I,I,O,4'hf,I,5'd5,32'h1234,Z9,I,I,32'h1234};
      vt[2]  = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd5, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};
      vt[3]  = '{I,4'hf,5'd1,32'ha1,Z9,O,O,O,Z32,5'd0, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};
      vt[4]  = '{I,4'hf,5'd2,32'ha2,Z9,O,O,O,Z32,5'd0, I,O,O,4'h0,I,5'd1,32'ha1,Z9,O,O,Z32};
      vt[5]  = '{I,4'hf,5'd3,32'ha3,Z9,O,O,O,Z32,5'd0, I,O,O,4'h0,I,5'd1,32'ha1,Z9,O,O,Z32};
      vt[6]  = '{I,4'hf,5'd4,32'ha4,Z9,O,O,O,Z32,5'd0, I,O,O,4'h0,I,5'd1,32'ha1,Z9,O,O,Z32};
      vt[7]  = '{I,4'hf,5'd5,32'ha5,Z9,O,O,O,Z32,5'd0, O,O,O,4'h0,I,5'd1,32'ha1,Z9,O,O,Z32};
      vt[8]  = '{I,4'hf,5'd5,32'ha5,Z9,I,O,O,Z32,5'd0, I,I,O,4'hf,I,5'd1,32'ha1,Z9,O,O,Z32};
      vt[9]  = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd0, I,I,O,4'hf,I,5'd2,32'ha2,Z9,O,O,Z32};
      vt[10] = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd0, I,I,O,4'hf,I,5'd3,32'ha3,Z9,O,O,Z32};
      vt[11] = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd0, I,I,O,4'hf,I,5'd4,32'ha4,Z9,O,O,Z32};
      vt[12] = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd0, I,I,O,4'hf,I,5'd5,32'ha5,Z9,O,O,Z32};
      vt[13] = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd0, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};
      vt[14] = '{I,4'hf,5'd7,32'ha,Z9,O,O,O,Z32,5'd7, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};
      vt[15] = '{I,4'hf,5'd7,32'hb,Z9,O,O,O,Z32,5'd7, I,O,O,4'h0,I,5'd7,32'ha,Z9,I,I,32'ha};
      vt[16] = '{I,4'h3,5'd7,32'hc,Z9,O,O,O,Z32,5'd7, I,O,O,4'h0,I,5'd7,32'ha,Z9,I,I,32'hb};
      vt[17] = '{O,4'h0,5'd0,Z32,Z9,O,O,O,Z32,5'd7, I,O,O,4'h0,I,5'd7,32'ha,Z9,I,O,32'hc};
      vt[18] = '{O,4'h0,5'd0,Z32,Z9,O,O,O,Z32,5'd0, I,O,O,4'h0,I,5'd7,32'ha,Z9,O,O,Z32};
      vt[19] = '{I,4'hf,5'd9,32'hd,Z9,I,I,O,Z32,5'd7, I,O,O,4'h0,I,5'd7,32'ha,Z9,I,O,32'hc};
      vt[20] = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd9, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};
      vt[21] = '{I,4'hf,5'd2,32'h11,Z9,O,O,O,Z32,5'd0, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};
      vt[22] = '{I,4'hf,5'd3,32'h22,OVB,O,O,O,Z32,5'd0, I,O,O,4'h0,I,5'd2,32'h11,Z9,O,O,Z32};
      vt[23] = '{I,4'hf,5'd4,32'h33,Z9,O,O,O,Z32,5'd0, I,O,O,4'h0,I,5'd2,32'h11,Z9,O,O,Z32};
      vt[24] = '{I,4'hf,5'd5,32'h44,Z9,O,O,O,Z32,5'd0, I,O,O,4'h0,I,5'd2,32'h11,Z9,O,O,Z32};
      vt[25] = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd4, I,I,O,4'hf,I,5'd2,32'h11,Z9,I,I,32'h33};
      vt[26] = '{I,4'hf,5'd6,32'h55,Z9,O,O,O,Z32,5'd4, I,I,I,4'h0,I,5'd3,32'h22,OVB,I,I,32'h33};
      vt[27] = '{O,4'h0,5'd0,Z32,Z9,O,O,O,Z32,5'd6, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};
      vt[28] = '{I,4'hf,5'd8,32'h77,MFB,O,O,O,Z32,5'd0, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};
      vt[29] = '{O,4'h0,5'd0,Z32,Z9,I,O,I,32'hdead,5'd8, I,I,O,4'hf,I,5'd8,32'hdead,MFB,I,O,32'h77};
      vt[30] = '{O,4'h0,5'd0,Z32,Z9,I,O,O,Z32,5'd0, I,O,O,4'h0,O,5'd0,Z32,Z9,O,O,Z32};

      idle();
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      #1;
      check("rst.rdy", in_ready, 1);
      check("rst.pop", c0_wb_valid, 0);
      check("rst.wsex", ws_ex, 0);
      check("rst.rfwe", rf_we, 0);
      check("rst.wa", rf_waddr, 0);
      check("rst.wd", rf_wdata, 0);
      check("rst.c0ex", c0_exception, 0);
      check("rst.pc", c0_wb_pc, 0);
      check("rst.bad", c0_badvaddr, 0);
      check("rst.hit", q_hit, 0);
      check("rst.qd", q_data, 0);
      check("rst.dpc", debug_wb_pc, 0);

      for (int i = 0; i < NV; i++) begin
         idle();
         in_valid  = vt[i].v;
         in_we     = vt[i].we;
         in_dest   = vt[i].d;
         in_result = vt[i].res;
         in_pc     = vt[i].res + 32'h1000;
         in_ex     = vt[i].ex;
         rf_grant  = vt[i].g;
         flush     = vt[i].fl;
         c0_valid  = vt[i].c0v;
         c0_res    = vt[i].c0r;
         q_reg     = {5'd0, vt[i].qr};
         #1;
         check($sformatf("v%0d.rdy", i), in_ready, vt[i].rdy);
         check($sformatf("v%0d.pop", i), c0_wb_valid, vt[i].pop);
         check($sformatf("v%0d.wsex", i), ws_ex, vt[i].wsex);
         check($sformatf("v%0d.rfwe", i), rf_we, vt[i].rfwe);
         if (vt[i].hd) begin
            check($sformatf("v%0d.wa", i), rf_waddr, vt[i].wa);
            check($sformatf("v%0d.c0ex", i), c0_exception,
                  vt[i].c0ex);
         end
         if (vt[i].hd || vt[i].c0v)
            check($sformatf("v%0d.wd", i), rf_wdata, vt[i].wd);
         check($sformatf("v%0d.hit", i), q_hit[0], vt[i].hit);
         check($sformatf("v%0d.fwd", i), q_fwd_ok[0], vt[i].fwd);
         check($sformatf("v%0d.qd", i), q_data[DW-1:0], vt[i].qd);
         @(posedge clk);
         #1;
      end

      idle();
      reset = 1;
      @(posedge clk);
      #1 reset = 0;
      mq.delete();
      for (int c = 0; c < 3000; c++) begin
         rand_in();
         #1;
         model_check(c);
         @(posedge clk);
         model_update();
         #1;
      end

      idle();
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_we = 4'hf;
         in_dest = 5'd10; in_result = 32'(k);
         @(posedge clk);
         #1;
      end
      in_dest = 5'd11;
      reset = 1;
      @(posedge clk);
      #1 reset = 0;
      idle();
      rf_grant = 1;
      q_reg = {5'd11, 5'd10};
      #1;
      check("mrst.rdy", in_ready, 1);
      check("mrst.hit", q_hit, 0);
      check("mrst.pop", c0_wb_valid, 0);
      check("mrst.rfwe", rf_we, 0);
      @(posedge clk);
      #1;
      check("mrst.hit2", q_hit, 0);
      check("mrst.rfwe2", rf_we, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
